// File: rtl/write_rows_pkg.sv
// Shared constants and state encodings for the row writer and its multiplier.
package write_rows_pkg;

    localparam int ADDR_W     = 48;
    localparam int WORD_SHIFT = 3;
    localparam int MUL_CYCLES = 48;

    // Top-level sequencing of the writer.
    typedef enum logic [1:0] {
        INIT_MUL = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Sub-steps of INIT_MUL: kick off the start-offset product, wait for it,
    // then wait for the stride product that is started back-to-back.
    typedef enum logic [1:0] {
        PH_KICK        = 2'd0,
        PH_WAIT_OFF    = 2'd1,
        PH_WAIT_STRIDE = 2'd2
    } mul_phase_t;

    // Memory requests are word addressed; the low bits of a byte address are dropped.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/write_rows_mul_48_seq.sv
// Shift-add 48x48 multiplier returning the product truncated to 48 bits.
// A start pulse loads the operands; busy_out stays high for 48 cycles and the
// product on p_out is valid from the cycle busy_out falls until the next start.
module mul_48_seq
    import write_rows_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] a_in,
    input  logic [ADDR_W-1:0] b_in,
    output logic              busy_out,
    output logic [ADDR_W-1:0] p_out
);

    logic [ADDR_W-1:0] mcand;
    logic [ADDR_W-1:0] mplier;
    logic [ADDR_W-1:0] acc;
    logic [5:0]        count;

    // One multiplier bit per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set; bits shifted past bit 47 are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            busy_out <= 1'b0;
        end else if (start_in) begin
            mcand    <= a_in;
            mplier   <= b_in;
            acc      <= '0;
            count    <= 6'(MUL_CYCLES);
            busy_out <= 1'b1;
        end else if (busy_out) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 6'd1;
            if (count == 6'd1) begin
                busy_out <= 1'b0;
            end
        end
    end

    assign p_out = acc;

endmodule

// File: rtl/write_rows.sv
// Row writer: pops 64-bit values from an FWFT FIFO and writes one value per
// selected row (start, start+skip, ... below num_rows) to memory, then raises
// done once every issued write has been acknowledged.
module write_rows
    import write_rows_pkg::*;
#(
    parameter int OUTSTANDING_W = 16,
    parameter int ADDR_W        = 48
) (
    input  logic              clk,
    input  logic              rst,
    output logic              done,
    input  logic [63:0]       num_rows_in,
    input  logic [63:0]       rows_size_in,
    input  logic [63:0]       row_start_in,
    input  logic [63:0]       row_skip_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic              input_empty_in,
    output logic              input_read_en_out,
    input  logic [63:0]       input_value_in,
    input  logic              row_wq_stall_in,
    output logic              row_wq_vld_out,
    output logic [ADDR_W-1:0] row_wq_vadr_out,
    output logic [63:0]       row_wq_data_out,
    input  logic              row_ws_vld_in
);

    state_t                   state;
    state_t                   state_next;
    mul_phase_t               mul_phase;

    logic                     mul_start;
    logic                     mul_busy;
    logic [47:0]              mul_a;
    logic [47:0]              mul_p;
    logic                     off_ready;
    logic                     stride_ready;

    logic [ADDR_W-1:0]        start_off;
    logic [ADDR_W-1:0]        stride;
    logic [ADDR_W-1:0]        byte_addr;
    logic [63:0]              row_idx;
    logic [64:0]              row_sum;
    logic                     last_row;

    logic [OUTSTANDING_W-1:0] outstanding;
    logic                     out_full;
    logic                     ack_ok;
    logic                     issue;

    logic                     unused_size_hi;

    // Row size is only meaningful over the address width.
    assign unused_size_hi = ^rows_size_in[63:48];

    // One multiplier is shared between the start-offset and stride products.
    mul_48_seq u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_in (mul_start),
        .a_in     (mul_a),
        .b_in     (rows_size_in[47:0]),
        .busy_out (mul_busy),
        .p_out    (mul_p)
    );

    assign off_ready    = (state == INIT_MUL) && (mul_phase == PH_WAIT_OFF) && !mul_busy;
    assign stride_ready = (state == INIT_MUL) && (mul_phase == PH_WAIT_STRIDE) && !mul_busy;

    // 65-bit sum so a row index that overflows 64 bits also ends the stream.
    assign row_sum  = {1'b0, row_idx} + {1'b0, row_skip_in};
    assign last_row = (row_sum >= {1'b0, num_rows_in});

    assign out_full = (outstanding == {OUTSTANDING_W{1'b1}});
    assign ack_ok   = row_ws_vld_in && (outstanding != '0);

    assign row_wq_vadr_out = word_addr(byte_addr);
    assign row_wq_data_out = input_value_in;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT_MUL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision for the writer sequence.
    always_comb begin
        state_next = state;
        case (state)
            INIT_MUL: begin
                if (stride_ready) begin
                    state_next = (row_start_in < num_rows_in) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (issue && last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding == '0) && !row_ws_vld_in) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = INIT_MUL;
            end
        endcase
    end

    // Same-cycle issue decision and multiplier kick-off for the current state.
    always_comb begin
        issue             = 1'b0;
        mul_start         = 1'b0;
        mul_a             = row_skip_in[47:0];
        if (state == RUN) begin
            issue = !input_empty_in && !row_wq_stall_in && !out_full;
        end
        if (state == INIT_MUL) begin
            if (mul_phase == PH_KICK) begin
                mul_start = 1'b1;
                mul_a     = row_start_in[47:0];
            end else if (off_ready) begin
                mul_start = 1'b1;
            end
        end
        row_wq_vld_out    = issue;
        input_read_en_out = issue;
    end

    // Address/row datapath: captures both products, then advances per write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_phase <= PH_KICK;
            start_off <= '0;
            stride    <= '0;
            byte_addr <= '0;
            row_idx   <= '0;
        end else begin
            case (state)
                INIT_MUL: begin
                    case (mul_phase)
                        PH_KICK: begin
                            mul_phase <= PH_WAIT_OFF;
                        end
                        PH_WAIT_OFF: begin
                            if (!mul_busy) begin
                                start_off <= mul_p;
                                mul_phase <= PH_WAIT_STRIDE;
                            end
                        end
                        PH_WAIT_STRIDE: begin
                            if (!mul_busy) begin
                                stride    <= mul_p;
                                byte_addr <= base_addr_in + start_off;
                                row_idx   <= row_start_in;
                            end
                        end
                        default: begin
                            mul_phase <= PH_KICK;
                        end
                    endcase
                end
                RUN: begin
                    if (issue) begin
                        byte_addr <= byte_addr + stride;
                        row_idx   <= row_idx + row_skip_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outstanding-write count; completions with nothing outstanding are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue, ack_ok})
                2'b10:   outstanding <= outstanding + OUTSTANDING_W'(1);
                2'b01:   outstanding <= outstanding - OUTSTANDING_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered, sticky done flag that follows entry into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state_next == DONE);
        end
    end

endmodule

// File: doc/write_rows.md
Name: write_rows

Overview:
- Write-side counterpart of the row streamer in the probe engine.
- Consumes a stream of 64-bit values from a first-word-fall-through FIFO interface and writes one value per selected row to memory.
- Row byte address = base_addr_in + row*rows_size_in; row runs start, start+skip, ... while row < num_rows.
- Issues word-addressed write requests with valid/stall, tracks write completions, and raises done when every write has been acknowledged.

Parameters:
- OUTSTANDING_W, 16, width of the outstanding-write counter.
- ADDR_W, 48, virtual address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- done  out  1  all rows written and acknowledged
- num_rows_in  in  64  row-index limit (exclusive)
- rows_size_in  in  64  row size in bytes; only [47:0] used
- row_start_in  in  64  first row index
- row_skip_in  in  64  row-index increment, must be >=1
- base_addr_in  in  48  byte base address of the table
- input_empty_in  in  1  source FIFO empty
- input_read_en_out  out  1  pop source FIFO
- input_value_in  in  64  source FIFO head (FWFT)
- row_wq_stall_in  in  1  memory write-request stall
- row_wq_vld_out  out  1  write request valid
- row_wq_vadr_out  out  48  word address (byte address >> 3)
- row_wq_data_out  out  64  write data
- row_ws_vld_in  in  1  write completion, one per request

Behaviour:
- Config inputs must be stable from reset deassertion until done.
- Reset (async): FSM=INIT_MUL, all counters/registers 0, done=0, row_wq_vld_out=0, input_read_en_out=0.
- INIT_MUL:
  - Sequential multiplier computes start_off = row_start_in[47:0]*rows_size_in[47:0], then stride = row_skip_in[47:0]*rows_size_in[47:0].
  - Each product is 48 cycles; products truncate to 48 bits.
  - Then byte_addr <= base_addr_in + start_off (mod 2^48) and row_idx <= row_start_in (64-bit).
  - Go to RUN if row_start_in < num_rows_in, else DRAIN.
- RUN:
  - issue = !input_empty_in && !row_wq_stall_in (combinational, same cycle).
  - row_wq_vld_out = input_read_en_out = issue.
  - row_wq_data_out = input_value_in.
  - row_wq_vadr_out = {3'd0, byte_addr[47:3]}; low 3 bits dropped, so rows must be 8-byte aligned.
  - On issue: byte_addr += stride (wraps mod 2^48); row_idx += row_skip_in.
  - If (row_idx + row_skip_in) >= num_rows_in, go to DRAIN. Compute with a 65-bit sum so 64-bit overflow also ends the stream.
- DRAIN: no requests issued; source FIFO never popped (surplus values remain for the consumer).
- Go to DONE when outstanding == 0 and no completion arrives this cycle.
- DONE: done=1 (registered, asserts the cycle after the transition), sticky until rst.
- Outstanding counter:
  - +1 on row_wq_vld_out, -1 on row_ws_vld_in; simultaneous events leave it unchanged.
  - Saturates at 0 on a spurious completion.
  - At 2^OUTSTANDING_W-1, issue is forced low.
- Stall and empty both block issue; no data is lost or duplicated across stall cycles.
- Reset mid-operation: all state cleared immediately. Completions of pre-reset writes arriving later are absorbed by the saturation rule.

Decomposition:
- Shared package: ADDR_W=48, WORD_SHIFT=3, FSM state encoding {INIT_MUL, RUN, DRAIN, DONE}.
- One sub-module, mul_48_seq: shift-add 48x48 multiplier, 48-bit truncated product.
  - Ports: clk, rst, start_in, a_in, b_in, busy_out, p_out.
  - Result valid on the cycle busy_out falls; 48-cycle latency.

Test Plan:
- Basic stream: num_rows=4, size=16, start=0, skip=1, base=0x1000; FIFO holds A,B,C,D with no stall.
  - Expect vadr 0x200, 0x202, 0x204, 0x206 with data A..D on consecutive cycles.
  - Ack all four; done rises one cycle after the last ack.
- Strided partition: num_rows=10, size=8, start=1, skip=3, base=0.
  - Expect exactly 3 writes, to vadr 1, 4, 7.
  - A 4th FIFO value is never popped.
- Backpressure: stall high 5 cycles mid-stream, then FIFO empty 3 cycles.
  - Expect vld=0 and read_en=0 during both.
  - Address/data sequence is identical to the no-stall run.
- Zero rows: start=5, num_rows=5.
  - Expect no requests and no pops; done=1 after the INIT_MUL phase.
- Simultaneous completion: issue and ack in the same cycle with outstanding=2.
  - Counter stays 2; done waits until outstanding reaches 0.
- Async reset asserted in RUN with 3 outstanding.
  - Outputs go 0 at once; the FSM restarts in INIT_MUL.
  - 3 late acks are ignored (counter stays 0); the new run completes normally.
